inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage of the multi-cycle processor, sitting directly upstream of the instruction ROM. It owns the program counter and drives the ROM's 17-bit byte address. It captures the combinational ROM word into an instruction register and hands it to decode over a valid/ready handshake. It also accepts PC redirects from branch/jump logic and flags misaligned or out-of-range fetch addresses.

## Interface
Parameters:
- ADDR_W, 17, ROM byte-address width (ROM uses addr[ADDR_W-1:2] as word index).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, IR reset/flush value (addi x0, x0, 0).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rom_addr  out  ADDR_W  byte address to instruction ROM, equal to pc[ADDR_W-1:0].
- rom_data  in  32  instruction word from ROM, combinational from rom_addr.
- inst_valid  out  1  ir holds an unconsumed instruction.
- inst_ready  in  1  decode accepts ir this cycle.
- ir  out  32  instruction register.
- pc  out  32  address of the instruction in ir, or of the pending fetch.
- redirect_valid  in  1  load redirect_pc into PC.
- redirect_pc  in  32  target address.
- fault  out  1  fetch address misaligned or out of ROM range; sticky.

## Operation
- States: FETCH, VALID, FAULT.
- FETCH:
  - If pc[1:0]!=0 or pc[31:ADDR_W]!=0, go to FAULT and leave ir unchanged.
  - Otherwise ir<=rom_data and go to VALID.
- VALID:
  - inst_valid=1; ir and pc are held stable.
  - Handshake (inst_valid & inst_ready): pc<=pc+4 (32-bit, wraps modulo 2^32), then go to FETCH.
- FAULT:
  - fault=1 and inst_valid=0.
  - Stays in FAULT until reset or a redirect.
- Redirect has priority over everything else, in any state:
  - pc<=redirect_pc, ir<=NOP_INST, fault<=0, next state FETCH.
  - The FETCH fault check then applies to the new PC.
- Redirect coincident with a handshake in VALID:
  - The instruction counts as accepted.
  - pc takes redirect_pc, not pc+4.
- Redirect in FETCH: the ROM capture for that cycle is discarded.
- Reset values:
  - state FETCH, pc=RESET_PC, ir=NOP_INST.
  - inst_valid=0, fault=0.
  - rom_addr=RESET_PC[ADDR_W-1:0].
- Reset mid-handshake: reset wins and the instruction is dropped.
- rom_addr is combinational from pc. It carries no extra register, because the ROM read is asynchronous.

## Timing
- Edge E0 with reset=1. Cycle after E0: state FETCH, rom_addr=RESET_PC.
- Edge E1: ir captured. inst_valid=1 from E1 onward.
- With inst_ready held at 1: the handshake occurs at E2 and the next ir is captured at E3. Peak throughput is one instruction per 2 cycles.
- inst_ready low: VALID is held indefinitely, with no change to ir or pc.
- Redirect sampled at edge En:
  - inst_valid=0 after En.
  - New ir at En+1.
  - inst_valid=1 after En+1, unless the new PC faults.
- Fault: fault=1 from the edge after FETCH sees the bad PC.
- inst_valid never depends combinationally on inst_ready.

## Configuration
- FETCH_PERF_EN defined:
  - Adds output fetch_count (32-bit).
  - Resets to 0 and increments by 1 on every handshake, including one coincident with a redirect.
  - Wraps at 2^32.
- FETCH_PERF_EN undefined:
  - No port and no counter logic.
  - All other behaviour identical.

## Test plan
- Reset release with ROM words addi/addi/add at 0/4/8 and inst_ready=1:
  - ir=32'h00200093 with pc=0.
  - Then 32'h00300113 with pc=4, then 32'h002081B3 with pc=8.
  - inst_valid pulses every 2nd cycle.
- inst_ready low for 5 cycles while in VALID: ir and pc stay constant and inst_valid stays 1.
- Handshake plus redirect_pc=0x18 in the same cycle: next pc=0x18 (not pc+4), and ir becomes ROM[6] one cycle later.
- redirect_pc=0x6 (misaligned):
  - fault=1 and inst_valid=0, held for 10 cycles.
  - A following redirect to 0x0 clears fault and refetches ROM[0].
- redirect_pc=0x0002_0000 (bit 17 set, with ADDR_W=17): fault=1 and ir remains NOP_INST.
- With FETCH_PERF_EN defined, 7 handshakes then reset:
  - fetch_count=7 before the reset.
  - fetch_count=0 the cycle after reset, with pc=RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, captures ROM words into ir and hands them to decode.
// Optional FETCH_PERF_EN adds a 32-bit handshake counter output, fetch_count.
module inst_fetch #(
    parameter int          ADDR_W   = 17,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       ir,
    output logic [31:0]       pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_count
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic        inst_valid_r;
    logic        fault_r;
    logic        handshake_s;

    // A fetch address is bad when it is not word aligned or lies beyond the ROM.
    function automatic logic fetch_addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:ADDR_W] != '0);
    endfunction

    assign handshake_s = inst_valid_r & inst_ready;

    // Fetch state machine; redirect overrides every state, reset overrides redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= FETCH;
            pc_r         <= RESET_PC;
            ir_r         <= NOP_INST;
            inst_valid_r <= 1'b0;
            fault_r      <= 1'b0;
        end else if (redirect_valid) begin
            state_r      <= FETCH;
            pc_r         <= redirect_pc;
            ir_r         <= NOP_INST;
            inst_valid_r <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (fetch_addr_bad(pc_r)) begin
                        state_r      <= FAULT;
                        fault_r      <= 1'b1;
                        inst_valid_r <= 1'b0;
                    end else begin
                        state_r      <= VALID;
                        ir_r         <= rom_data;
                        inst_valid_r <= 1'b1;
                    end
                end
                VALID: begin
                    if (inst_ready) begin
                        state_r      <= FETCH;
                        pc_r         <= pc_r + 32'd4;
                        inst_valid_r <= 1'b0;
                    end else begin
                        state_r      <= VALID;
                    end
                end
                FAULT: begin
                    state_r      <= FAULT;
                    fault_r      <= 1'b1;
                    inst_valid_r <= 1'b0;
                end
                default: begin
                    state_r      <= FETCH;
                    inst_valid_r <= 1'b0;
                    fault_r      <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_r;

    // Count accepted instructions, including those accepted alongside a redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_r <= 32'd0;
        end else if (handshake_s) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    assign fetch_count = fetch_count_r;
`else
    logic unused_handshake_s;
    assign unused_handshake_s = handshake_s;
`endif

    // The ROM read is asynchronous, so the address comes straight from the PC.
    assign rom_addr   = pc_r[ADDR_W-1:0];
    assign pc         = pc_r;
    assign ir         = ir_r;
    assign inst_valid = inst_valid_r;
    assign fault      = fault_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random traffic against a
// transaction-level model of the fetch stage and an array-backed ROM.
module tb_inst_fetch;

    localparam int          ADDR_W   = 17;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] ROM_BYTES = 32'd1 << ADDR_W;

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       ir;
    logic [31:0]       pc;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              fault;
`ifdef FETCH_PERF_EN
    logic [31:0]       fetch_count;
`endif

    logic [31:0] rom_mem [0:32767];

    int compared_cnt;
    int mismatched_cnt;

    // model state: what decode should see
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        m_valid;
    logic        m_fault;
    logic        m_pending;
    logic [31:0] m_count;

    inst_fetch #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .ir            (ir),
        .pc            (pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fault         (fault)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    assign rom_data = rom_mem[rom_addr[ADDR_W-1:2]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared_cnt++;
        if (got !== exp) begin
            mismatched_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference: a pending fetch either faults or delivers ROM[pc/4];
    // a delivered instruction waits for acceptance, then the PC advances by one word.
    task automatic model_step();
        logic hs;
        if (reset) begin
            m_pc = RESET_PC; m_ir = NOP_INST; m_valid = 1'b0;
            m_fault = 1'b0; m_pending = 1'b1; m_count = 32'd0;
        end else begin
            hs = m_valid && inst_ready;
            if (hs) m_count = m_count + 32'd1;
            if (redirect_valid) begin
                m_pc = redirect_pc; m_ir = NOP_INST; m_valid = 1'b0;
                m_fault = 1'b0; m_pending = 1'b1;
            end else if (m_pending) begin
                m_pending = 1'b0;
                if ((m_pc % 32'd4) != 32'd0 || m_pc >= ROM_BYTES) begin
                    m_fault = 1'b1;
                end else begin
                    m_ir = rom_mem[m_pc / 32'd4];
                    m_valid = 1'b1;
                end
            end else if (hs) begin
                m_pc = m_pc + 32'd4;
                m_valid = 1'b0;
                m_pending = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check("pc", pc, m_pc);
        check("ir", ir, m_ir);
        check("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
        check("fault", {31'd0, fault}, {31'd0, m_fault});
        check("rom_addr", {15'd0, rom_addr}, {15'd0, m_pc[ADDR_W-1:0]});
`ifdef FETCH_PERF_EN
        check("fetch_count", fetch_count, m_count);
`endif
    endtask

    task automatic set_in(input logic rst, input logic rdy, input logic rv, input logic [31:0] rp);
        reset = rst; inst_ready = rdy; redirect_valid = rv; redirect_pc = rp;
    endtask

    initial begin
        int sel;
        int budget;
        compared_cnt = 0;
        mismatched_cnt = 0;
        m_pc = RESET_PC; m_ir = NOP_INST; m_valid = 1'b0;
        m_fault = 1'b0; m_pending = 1'b1; m_count = 32'd0;
        for (int i = 0; i < 32768; i++) rom_mem[i] = $urandom;
        rom_mem[0] = 32'h0020_0093;
        rom_mem[1] = 32'h0030_0113;
        rom_mem[2] = 32'h0020_81B3;

        set_in(1'b1, 1'b1, 1'b0, 32'd0);
        cycle(); cycle();
        check("rst_ir", ir, NOP_INST);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);

        // straight-line fetch of the first three words
        set_in(1'b0, 1'b1, 1'b0, 32'd0);
        cycle();
        check("ir0", ir, 32'h0020_0093); check("pc0", pc, 32'd0);
        check("v0", {31'd0, inst_valid}, 32'd1);
        cycle();
        check("v0_off", {31'd0, inst_valid}, 32'd0);
        cycle();
        check("ir1", ir, 32'h0030_0113); check("pc1", pc, 32'd4);
        cycle(); cycle();
        check("ir2", ir, 32'h0020_81B3); check("pc2", pc, 32'd8);

        // stall in VALID
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_ir", ir, 32'h0020_81B3);
            check("stall_pc", pc, 32'd8);
            check("stall_v", {31'd0, inst_valid}, 32'd1);
        end

        // handshake coincident with redirect
        set_in(1'b0, 1'b1, 1'b1, 32'h18);
        cycle();
        check("redir_pc", pc, 32'h18);
        check("redir_v", {31'd0, inst_valid}, 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        cycle();
        check("redir_ir", ir, rom_mem[6]);

        // misaligned redirect, then recovery
        set_in(1'b0, 1'b1, 1'b1, 32'h6);
        cycle();
        set_in(1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("mis_fault", {31'd0, fault}, 32'd1);
            check("mis_v", {31'd0, inst_valid}, 32'd0);
        end
        set_in(1'b0, 1'b0, 1'b1, 32'h0);
        cycle();
        check("clr_fault", {31'd0, fault}, 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 32'd0);
        cycle();
        check("refetch", ir, 32'h0020_0093);

        // out-of-range redirect
        set_in(1'b0, 1'b1, 1'b1, 32'h0002_0000);
        cycle();
        set_in(1'b0, 1'b1, 1'b0, 32'd0);
        cycle(); cycle();
        check("oor_fault", {31'd0, fault}, 32'd1);
        check("oor_ir", ir, NOP_INST);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 3);
            set_in(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 15) == 0),
                   (sel < 2) ? {15'd0, 15'($urandom_range(0, 32767)), 2'b00} :
                   (sel == 2) ? {15'd0, 15'($urandom_range(0, 32767)), 2'b10} : 32'($urandom));
            cycle();
        end

        // seven handshakes, then reset
        set_in(1'b1, 1'b1, 1'b0, 32'd0);
        cycle();
        set_in(1'b0, 1'b1, 1'b0, 32'd0);
        budget = 0;
        while (m_count != 32'd7 && budget < 100) begin
            cycle();
            budget++;
        end
        check("hs7_reached", m_count, 32'd7);
`ifdef FETCH_PERF_EN
        check("count7", fetch_count, 32'd7);
`endif
        set_in(1'b1, 1'b0, 1'b0, 32'd0);
        cycle();
        check("rst_pc", pc, RESET_PC);
`ifdef FETCH_PERF_EN
        check("count0", fetch_count, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatched_cnt);
        $finish;
    end

endmodule
